hazard_controller: RTL and testbench

- Central pipeline sequencer for the RV32I core.
- Drives the stall and flush controls of the PC, the IF/ID fetch pipeline register and the ID/EX register.
- Replaces the ad-hoc flush flag and load stall inside the fetch register with one arbitrated FSM that handles:
  - control-transfer flushes (JAL/JALR/taken branch),
  - load-use stalls,
  - data-memory wait freezes.
- Sits beside the fetch pipeline register; the datapath consumes its outputs directly.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_detect.sv | 23 ++
 rtl/hazard_controller.sv | 157 +++++++++++++++
 tb/tb_hazard_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and constants for the pipeline hazard sequencer and forwarding logic.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH      = 2'd1,
    LOAD_STALL = 2'd2,
    MEM_WAIT   = 2'd3
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;
  localparam int         CNT_W  = 3;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: EX load whose destination feeds a source register of the ID instruction.
// Purely combinational, zero latency, no flow control.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_use_rs1 && (ex_rd == id_rs1);
  assign rs2_hit  = id_use_rs2 && (ex_rd == id_rs2);
  // x0 is never really written, so a load into it cannot create a dependency.
  assign load_use = ex_mem_read && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer driving PC/IF-ID/ID-EX stall and flush; zero-latency outputs from registered state.
// Data-memory wait freezes everything; optional HAZARD_PERF_CNT_EN adds stall/flush cycle counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES      = 2,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jal,
  input  logic        jalr,
  input  logic        branch_taken,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_e           state, state_nxt;
  state_e           resume, resume_nxt;
  state_e           eff_state;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic redirect, load_use, mem_wait;
  logic pc_stall_c, ifid_stall_c, ifid_flush_c, idex_flush_c;

  hazard_detect u_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .load_use    (load_use)
  );

  assign redirect = jal || jalr || branch_taken;
  assign mem_wait = dmem_req && !dmem_ready;

  always_comb begin
    // Leaving MEM_WAIT behaves exactly like the saved state would this cycle.
    eff_state    = (state == MEM_WAIT) ? resume : state;
    state_nxt    = state;
    resume_nxt   = resume;
    cnt_nxt      = cnt;
    pc_stall_c   = 1'b0;
    ifid_stall_c = 1'b0;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;

    if (mem_wait) begin
      pc_stall_c   = 1'b1;
      ifid_stall_c = 1'b1;
      state_nxt    = MEM_WAIT;
      resume_nxt   = eff_state;
    end else if (redirect) begin
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nxt = FLUSH;
        cnt_nxt   = FLUSH_RELOAD;
      end else begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    end else begin
      case (eff_state)
        FLUSH: begin
          ifid_flush_c = 1'b1;
          if (cnt <= CNT_ONE) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            state_nxt = FLUSH;
            cnt_nxt   = cnt - CNT_ONE;
          end
        end
        LOAD_STALL: begin
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
          idex_flush_c = 1'b1;
          if (cnt <= CNT_ONE) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            state_nxt = LOAD_STALL;
            cnt_nxt   = cnt - CNT_ONE;
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          if (load_use) begin
            pc_stall_c   = 1'b1;
            ifid_stall_c = 1'b1;
            idex_flush_c = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_nxt = LOAD_STALL;
              cnt_nxt   = STALL_RELOAD;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      resume <= RUN;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      resume <= resume_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Gated by reset so an in-flight sequence disappears the instant reset asserts.
  assign pc_stall   = rst_n && pc_stall_c;
  assign ifid_flush = rst_n && ifid_flush_c;
  assign ifid_stall = rst_n && ifid_stall_c && !ifid_flush_c;
  assign idex_flush = rst_n && idex_flush_c;
  assign busy       = rst_n && (state != RUN);

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      stall_count <= stall_count + {31'd0, pc_stall};
      flush_count <= flush_count + {31'd0, ifid_flush};
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench: two DUT configurations against a remaining-cycles reference model.
module tb_hazard_controller;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_flush;
    logic busy;
  } out_t;

  typedef struct packed {
    logic       jal;
    logic       jalr;
    logic       br;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       dreq;
    logic       drdy;
  } in_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       jal = 1'b0, jalr = 1'b0, branch_taken = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_mem_read = 1'b0;
  logic       dmem_req = 1'b0, dmem_ready = 1'b0;

  logic pc_stall0, ifid_stall0, ifid_flush0, idex_flush0, busy0;
  logic pc_stall1, ifid_stall1, ifid_flush1, idex_flush1, busy1;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count0, flush_count0, stall_count1, flush_count1;
`endif

  always #5 clk = ~clk;

  hazard_controller #(.FLUSH_CYCLES(2), .LOAD_STALL_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .jal(jal), .jalr(jalr), .branch_taken(branch_taken),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall0), .ifid_stall(ifid_stall0), .ifid_flush(ifid_flush0),
    .idex_flush(idex_flush0), .busy(busy0)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(stall_count0), .flush_count(flush_count0)
`endif
  );

  hazard_controller #(.FLUSH_CYCLES(3), .LOAD_STALL_CYCLES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .jal(jal), .jalr(jalr), .branch_taken(branch_taken),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall1), .ifid_stall(ifid_stall1), .ifid_flush(ifid_flush1),
    .idex_flush(idex_flush1), .busy(busy1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(stall_count1), .flush_count(flush_count1)
`endif
  );

  out_t act0, act1;
  assign act0 = {pc_stall0, ifid_stall0, ifid_flush0, idex_flush0, busy0};
  assign act1 = {pc_stall1, ifid_stall1, ifid_flush1, idex_flush1, busy1};

  // Reference model: how many flush / stall cycles are still owed, and whether the
  // previous cycle was a memory wait.
  int          flush_cfg [2] = '{2, 3};
  int          stall_cfg [2] = '{1, 2};
  int          flush_rem [2];
  int          stall_rem [2];
  bit          prev_wait [2];
  int unsigned m_stall   [2];
  int unsigned m_flush   [2];

  out_t exp_q0[$];
  out_t exp_q1[$];
  out_t e0, e1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  function automatic out_t model_step(input int k, input in_t v);
    out_t o;
    bit   mw, rdr, lu;
    mw  = v.dreq && !v.drdy;
    rdr = v.jal || v.jalr || v.br;
    lu  = v.mr && (v.rd != 5'd0) && ((v.u1 && v.rd == v.rs1) || (v.u2 && v.rd == v.rs2));
    o = '0;
    o.busy = (flush_rem[k] > 0) || (stall_rem[k] > 0) || prev_wait[k];
    if (mw) begin
      o.pc_stall = 1'b1; o.ifid_stall = 1'b1;
    end else if (rdr) begin
      o.ifid_flush = 1'b1; o.idex_flush = 1'b1;
      flush_rem[k] = flush_cfg[k] - 1;
      stall_rem[k] = 0;
    end else if (flush_rem[k] > 0) begin
      o.ifid_flush = 1'b1;
      flush_rem[k]--;
    end else if (stall_rem[k] > 0) begin
      o.pc_stall = 1'b1; o.ifid_stall = 1'b1; o.idex_flush = 1'b1;
      stall_rem[k]--;
    end else if (lu) begin
      o.pc_stall = 1'b1; o.ifid_stall = 1'b1; o.idex_flush = 1'b1;
      stall_rem[k] = stall_cfg[k] - 1;
    end
    prev_wait[k] = mw;
    m_stall[k] += o.pc_stall;
    m_flush[k] += o.ifid_flush;
    return o;
  endfunction

  task automatic drive(input in_t v);
    jal = v.jal; jalr = v.jalr; branch_taken = v.br;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    ex_rd = v.rd; ex_mem_read = v.mr; dmem_req = v.dreq; dmem_ready = v.drdy;
  endtask

  task automatic apply(input in_t v);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(v);
    exp_q0.push_back(model_step(0, v));
    exp_q1.push_back(model_step(1, v));
  endtask

  function automatic in_t rand_in();
    in_t v;
    v.jal  = ($urandom_range(0, 19) == 0);
    v.jalr = ($urandom_range(0, 29) == 0);
    v.br   = ($urandom_range(0, 11) == 0);
    v.rs1  = 5'($urandom_range(0, 3));
    v.rs2  = 5'($urandom_range(0, 3));
    v.u1   = 1'($urandom_range(0, 1));
    v.u2   = 1'($urandom_range(0, 1));
    v.rd   = 5'($urandom_range(0, 3));
    v.mr   = ($urandom_range(0, 2) == 0);
    v.dreq = ($urandom_range(0, 4) == 0);
    v.drdy = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Reset is asserted mid-cycle with busy inputs; every output must read zero.
  task automatic do_reset(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      rst_n = 1'b0;
      drive(rand_in());
      for (int k = 0; k < 2; k++) begin
        flush_rem[k] = 0; stall_rem[k] = 0; prev_wait[k] = 1'b0;
        m_stall[k] = 0; m_flush[k] = 0;
      end
      exp_q0.push_back('0);
      exp_q1.push_back('0);
    end
  endtask

  task automatic check(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got {pc_stall,ifid_stall,ifid_flush,idex_flush,busy}=%b expected %b",
               name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (exp_q0.size() > 0) begin
      e0 = exp_q0.pop_front();
      check("cfg_f2_l1", act0, e0);
    end
    if (exp_q1.size() > 0) begin
      e1 = exp_q1.pop_front();
      check("cfg_f3_l2", act1, e1);
    end
  end

  initial begin
    in_t v;
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t v;
    do_reset(2);
    v = '0; apply(v); apply(v);

    // Single JAL from RUN, then idle.
    v = '0; v.jal = 1'b1; apply(v);
    v = '0; repeat (3) apply(v);

    // Load-use on rs2, then same with x0 destination.
    v = '0; v.mr = 1'b1; v.rd = 5'd5; v.rs2 = 5'd5; v.u2 = 1'b1; apply(v);
    v = '0; repeat (3) apply(v);
    v = '0; v.mr = 1'b1; v.rd = 5'd0; v.rs2 = 5'd0; v.u2 = 1'b1; apply(v);
    v = '0; apply(v);

    // Load-use and taken branch together: the flush wins.
    v = '0; v.mr = 1'b1; v.rd = 5'd7; v.rs1 = 5'd7; v.u1 = 1'b1; v.br = 1'b1; apply(v);
    v = '0; v.mr = 1'b1; v.rd = 5'd7; v.rs1 = 5'd7; v.u1 = 1'b1; apply(v);
    v = '0; repeat (3) apply(v);

    // Memory wait in the middle of a flush, then release.
    v = '0; v.jalr = 1'b1; apply(v);
    v = '0; v.dreq = 1'b1; repeat (3) apply(v);
    v = '0; v.dreq = 1'b1; v.drdy = 1'b1; apply(v);
    v = '0; repeat (3) apply(v);

    // Memory wait during a multi-cycle load stall, redirect on release.
    v = '0; v.mr = 1'b1; v.rd = 5'd3; v.rs1 = 5'd3; v.u1 = 1'b1; apply(v);
    v = '0; v.dreq = 1'b1; repeat (2) apply(v);
    v = '0; v.jal = 1'b1; apply(v);
    v = '0; repeat (4) apply(v);

    // Reset mid-flush.
    v = '0; v.jal = 1'b1; apply(v);
    do_reset(2);
    v = '0; repeat (3) apply(v);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset(1);
      else apply(rand_in());
    end

    v = '0; apply(v);
    @(posedge clk);
    @(negedge clk);
    #1;

`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if (stall_count0 !== m_stall[0] || flush_count0 !== m_flush[0]) begin
      n_fail++;
      $display("FAIL perf_cnt0: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
               stall_count0, flush_count0, m_stall[0], m_flush[0]);
    end
    n_checks++;
    if (stall_count1 !== m_stall[1] || flush_count1 !== m_flush[1]) begin
      n_fail++;
      $display("FAIL perf_cnt1: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
               stall_count1, flush_count1, m_stall[1], m_flush[1]);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
